// File: rtl/simm_dram_pkg.sv
// Shared types, field geometry and helpers for the SIMM DRAM controller.
package simm_dram_pkg;

    localparam int BANK_W  = 3;
    localparam int ROW_W   = 9;
    localparam int COL_W   = 9;
    localparam int ADDR_W  = BANK_W + ROW_W + COL_W;
    localparam int DATA_W  = 16;
    localparam int PHASE_W = 4;

    // Host address layout: {bank, row, col}
    localparam int COL_LSB  = 0;
    localparam int COL_MSB  = COL_LSB + COL_W - 1;
    localparam int ROW_LSB  = COL_MSB + 1;
    localparam int ROW_MSB  = ROW_LSB + ROW_W - 1;
    localparam int BANK_LSB = ROW_MSB + 1;
    localparam int BANK_MSB = BANK_LSB + BANK_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_COL     = 3'd2,
        ST_PRE     = 3'd3,
        ST_REF_CAS = 3'd4,
        ST_REF_RAS = 3'd5
    } state_e;

    // Array address bus: bank on top, middle field zero, row or column in the low field.
    function automatic logic [ADDR_W-1:0] mux_addr(input logic [BANK_W-1:0] bank,
                                                   input logic [COL_W-1:0]  low);
        return {bank, {ROW_W{1'b0}}, low};
    endfunction

    // Phase counter load value for a state lasting 'cycles' clocks.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/simm_refresh_timer.sv
// Free-running refresh interval timer with pending flag and sticky overrun flag.
import simm_dram_pkg::*;

module simm_refresh_timer #(
    parameter int REF_INT = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic ref_pending,
    output logic ref_pending_next,
    output logic ref_miss
);

    localparam int CNT_W = $clog2(REF_INT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INT - 1);

    logic [CNT_W-1:0] count_r;
    logic             pending_r;
    logic             miss_r;
    logic             expire_s;
    logic             pending_next_s;
    logic             miss_next_s;

    // Next pending/miss: a new interval beats a same-cycle clear; overrun only if still owed
    always_comb begin
        expire_s       = 1'b0;
        pending_next_s = pending_r;
        miss_next_s    = miss_r;
        if (count_r == CNT_LAST) begin
            expire_s       = 1'b1;
            pending_next_s = 1'b1;
            if (pending_r && !clear) begin
                miss_next_s = 1'b1;
            end else begin
                miss_next_s = miss_r;
            end
        end else if (clear) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Interval counter plus pending/miss state, running in every controller state
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= {CNT_W{1'b0}};
            pending_r <= 1'b0;
            miss_r    <= 1'b0;
        end else begin
            if (expire_s) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            pending_r <= pending_next_s;
            miss_r    <= miss_next_s;
        end
    end

    assign ref_pending      = pending_r;
    assign ref_pending_next = pending_next_s;
    assign ref_miss         = miss_r;

endmodule

// File: rtl/simm_dram_ctrl.sv
// Host-side DRAM controller: single-word accesses as RAS/CAS/WE sequences with
// multiplexed row/column address, plus rotating CAS-before-RAS refresh.
import simm_dram_pkg::*;

module simm_dram_ctrl #(
    parameter int T_RCD     = 2,
    parameter int T_CAS     = 2,
    parameter int T_RP      = 2,
    parameter int T_CSR     = 1,
    parameter int T_RAS_REF = 3,
    parameter int REF_INT   = 780
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ras,
    output logic              mem_cas,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] mem_dout,
    output logic              ref_miss
);

    localparam logic [PHASE_W-1:0] RCD_LOAD = phase_load(T_RCD);
    localparam logic [PHASE_W-1:0] CAS_LOAD = phase_load(T_CAS);
    localparam logic [PHASE_W-1:0] RP_LOAD  = phase_load(T_RP);
    localparam logic [PHASE_W-1:0] CSR_LOAD = phase_load(T_CSR);
    localparam logic [PHASE_W-1:0] RAS_LOAD = phase_load(T_RAS_REF);

    state_e              state_r;
    logic [PHASE_W-1:0]  phase_r;
    logic [BANK_W-1:0]   lat_bank_r;
    logic [COL_W-1:0]    lat_col_r;
    logic                lat_we_r;
    logic [BANK_W-1:0]   ref_bank_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_ras_r;
    logic                mem_cas_r;
    logic                mem_we_r;
    logic [DATA_W-1:0]   mem_dout_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                ack_r;
    logic                ready_r;

    logic                ref_clear_s;
    logic                ref_pending_s;
    logic                ref_pending_next_s;
    logic                ref_miss_s;

    simm_refresh_timer #(
        .REF_INT (REF_INT)
    ) u_refresh_timer (
        .clk              (clk),
        .rst              (rst),
        .clear            (ref_clear_s),
        .ref_pending      (ref_pending_s),
        .ref_pending_next (ref_pending_next_s),
        .ref_miss         (ref_miss_s)
    );

    // Refresh is retired on the final REF_RAS cycle
    always_comb begin
        ref_clear_s = 1'b0;
        if ((state_r == ST_REF_RAS) && (phase_r == 4'd0)) begin
            ref_clear_s = 1'b1;
        end else begin
            ref_clear_s = 1'b0;
        end
    end

    // Access/refresh sequencer; every output is set on the edge that enters its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            phase_r    <= 4'd0;
            lat_bank_r <= {BANK_W{1'b0}};
            lat_col_r  <= {COL_W{1'b0}};
            lat_we_r   <= 1'b0;
            ref_bank_r <= {BANK_W{1'b0}};
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_ras_r  <= 1'b1;
            mem_cas_r  <= 1'b1;
            mem_we_r   <= 1'b1;
            mem_dout_r <= {DATA_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            ack_r      <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            ack_r   <= 1'b0;
            ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ref_pending_s) begin
                        state_r    <= ST_REF_CAS;
                        phase_r    <= CSR_LOAD;
                        mem_addr_r <= {ref_bank_r, {(ROW_W + COL_W){1'b0}}};
                        mem_ras_r  <= 1'b1;
                        mem_cas_r  <= 1'b0;
                        mem_we_r   <= 1'b1;
                    end else if (req) begin
                        state_r    <= ST_ROW;
                        phase_r    <= RCD_LOAD;
                        lat_bank_r <= req_addr[BANK_MSB:BANK_LSB];
                        lat_col_r  <= req_addr[COL_MSB:COL_LSB];
                        lat_we_r   <= req_we;
                        mem_dout_r <= req_wdata;
                        mem_addr_r <= mux_addr(req_addr[BANK_MSB:BANK_LSB],
                                               req_addr[ROW_MSB:ROW_LSB]);
                        mem_ras_r  <= 1'b0;
                        mem_cas_r  <= 1'b1;
                        mem_we_r   <= 1'b1;
                    end else begin
                        ready_r <= ~ref_pending_next_s;
                    end
                end
                ST_ROW: begin
                    if (phase_r == 4'd0) begin
                        state_r    <= ST_COL;
                        phase_r    <= CAS_LOAD;
                        mem_addr_r <= mux_addr(lat_bank_r, lat_col_r);
                        mem_ras_r  <= 1'b0;
                        mem_cas_r  <= 1'b0;
                        mem_we_r   <= ~lat_we_r;
                    end else begin
                        phase_r <= phase_r - 4'd1;
                    end
                end
                ST_COL: begin
                    if (phase_r == 4'd0) begin
                        if (!lat_we_r) begin
                            rdata_r <= mem_din;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r   <= ST_PRE;
                        phase_r   <= RP_LOAD;
                        mem_ras_r <= 1'b1;
                        mem_cas_r <= 1'b1;
                        mem_we_r  <= 1'b1;
                        ack_r     <= 1'b1;
                    end else begin
                        phase_r <= phase_r - 4'd1;
                    end
                end
                ST_PRE: begin
                    if (phase_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        ready_r <= ~ref_pending_next_s;
                    end else begin
                        phase_r <= phase_r - 4'd1;
                    end
                end
                ST_REF_CAS: begin
                    if (phase_r == 4'd0) begin
                        state_r   <= ST_REF_RAS;
                        phase_r   <= RAS_LOAD;
                        mem_ras_r <= 1'b0;
                        mem_cas_r <= 1'b0;
                    end else begin
                        phase_r <= phase_r - 4'd1;
                    end
                end
                ST_REF_RAS: begin
                    if (phase_r == 4'd0) begin
                        state_r    <= ST_PRE;
                        phase_r    <= RP_LOAD;
                        mem_ras_r  <= 1'b1;
                        mem_cas_r  <= 1'b1;
                        mem_we_r   <= 1'b1;
                        ref_bank_r <= ref_bank_r + 3'd1;
                    end else begin
                        phase_r <= phase_r - 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    phase_r   <= 4'd0;
                    mem_ras_r <= 1'b1;
                    mem_cas_r <= 1'b1;
                    mem_we_r  <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_r;
    assign ack      = ack_r;
    assign rdata    = rdata_r;
    assign mem_addr = mem_addr_r;
    assign mem_ras  = mem_ras_r;
    assign mem_cas  = mem_cas_r;
    assign mem_we   = mem_we_r;
    assign mem_dout = mem_dout_r;
    assign ref_miss = ref_miss_s;

endmodule

// File: tb/tb_simm_dram_ctrl.sv
// Directed bench for simm_dram_ctrl: a vector table for access/reset timing on a
// default-parameter instance, plus refresh sequences on short-interval instances.
module tb_simm_dram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default timing, long refresh interval
    logic        a_req, a_req_we, a_ready, a_ack, a_ras, a_cas, a_we, a_miss;
    logic [20:0] a_req_addr, a_addr;
    logic [15:0] a_req_wdata, a_din, a_rdata, a_dout;
    // Instance B: default timing, REF_INT=16
    logic        b_req, b_req_we, b_ready, b_ack, b_ras, b_cas, b_we, b_miss;
    logic [20:0] b_req_addr, b_addr;
    logic [15:0] b_req_wdata, b_din, b_rdata, b_dout;
    // Instance C: REF_INT=16, T_RP=15
    logic        c_req, c_req_we, c_ready, c_ack, c_ras, c_cas, c_we, c_miss;
    logic [20:0] c_req_addr, c_addr;
    logic [15:0] c_req_wdata, c_din, c_rdata, c_dout;

    simm_dram_ctrl u_dut_a (
        .clk(clk), .rst(rst), .req(a_req), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .ready(a_ready), .ack(a_ack), .rdata(a_rdata),
        .mem_addr(a_addr), .mem_ras(a_ras), .mem_cas(a_cas), .mem_we(a_we),
        .mem_din(a_din), .mem_dout(a_dout), .ref_miss(a_miss)
    );

    simm_dram_ctrl #(.REF_INT(16)) u_dut_b (
        .clk(clk), .rst(rst), .req(b_req), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .ready(b_ready), .ack(b_ack), .rdata(b_rdata),
        .mem_addr(b_addr), .mem_ras(b_ras), .mem_cas(b_cas), .mem_we(b_we),
        .mem_din(b_din), .mem_dout(b_dout), .ref_miss(b_miss)
    );

    simm_dram_ctrl #(.REF_INT(16), .T_RP(15)) u_dut_c (
        .clk(clk), .rst(rst), .req(c_req), .req_we(c_req_we), .req_addr(c_req_addr),
        .req_wdata(c_req_wdata), .ready(c_ready), .ack(c_ack), .rdata(c_rdata),
        .mem_addr(c_addr), .mem_ras(c_ras), .mem_cas(c_cas), .mem_we(c_we),
        .mem_din(c_din), .mem_dout(c_dout), .ref_miss(c_miss)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [20:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [20:0] e_addr;
        logic        e_ras;
        logic        e_cas;
        logic        e_we;
        logic        e_ack;
        logic        e_ready;
        logic [15:0] e_rdata;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic add_vec(input logic rst_v, input logic req_v, input logic we_v,
                           input logic [20:0] addr_v, input logic [15:0] wd_v,
                           input logic [15:0] din_v, input logic [20:0] ea,
                           input logic er, input logic ec, input logic ew,
                           input logic eack, input logic erdy,
                           input logic [15:0] erd, input logic [15:0] edo);
        vec_t v;
        v.rst = rst_v; v.req = req_v; v.we = we_v; v.addr = addr_v;
        v.wdata = wd_v; v.din = din_v; v.e_addr = ea; v.e_ras = er; v.e_cas = ec;
        v.e_we = ew; v.e_ack = eack; v.e_ready = erdy; v.e_rdata = erd; v.e_dout = edo;
        vecs.push_back(v);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int          cyc;
    logic        got;
    int          n_ev;
    int          last_fall;
    logic        prev_cas;
    logic        ras_chk;
    logic        seen_miss;
    logic        sticky_bad;
    logic [2:0]  exp_bank;

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_req_we = 1'b0; a_req_addr = 21'h0; a_req_wdata = 16'h0; a_din = 16'h0;
        b_req = 1'b0; b_req_we = 1'b0; b_req_addr = 21'h0; b_req_wdata = 16'h0; b_din = 16'h0;
        c_req = 1'b0; c_req_we = 1'b0; c_req_addr = 21'h0; c_req_wdata = 16'h0; c_din = 16'h0;

        //       rst   req   we    addr        wdata     din       e_addr      ras   cas   we    ack   rdy   rdata     dout
        // reset, then idle
        add_vec(1'b1, 1'b0, 1'b0, 21'h000000, 16'h0000, 16'h0000, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b0, 1'b0, 21'h000000, 16'h0000, 16'h0000, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        // read 1AB3C5: bank 6, row 159, col 1C5
        add_vec(1'b0, 1'b1, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h180159, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h180159, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h1801C5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h1801C5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h1801C5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000);
        add_vec(1'b0, 1'b0, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h1801C5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
        add_vec(1'b0, 1'b0, 1'b0, 21'h1AB3C5, 16'h0000, 16'hBEEF, 21'h1801C5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000);
        // write 000010 data 1234: early write, we low only in COL
        add_vec(1'b0, 1'b1, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b1, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b1, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b1, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b1, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b0, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234);
        add_vec(1'b0, 1'b0, 1'b1, 21'h000010, 16'h1234, 16'h0000, 21'h000010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h1234);
        // read 0A5A5A (bank 2, row 12D, col 05A), reset in first COL cycle
        add_vec(1'b0, 1'b1, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h08012D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h08012D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
        add_vec(1'b0, 1'b1, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h08005A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000);
        add_vec(1'b1, 1'b0, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b0, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        add_vec(1'b0, 1'b0, 1'b0, 21'h0A5A5A, 16'h0000, 16'hCAFE, 21'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            a_req       = vecs[i].req;
            a_req_we    = vecs[i].we;
            a_req_addr  = vecs[i].addr;
            a_req_wdata = vecs[i].wdata;
            a_din       = vecs[i].din;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {5'd0, a_addr, a_ras, a_cas, a_we, a_ack, a_ready, a_rdata, a_dout, a_miss},
                  {5'd0, vecs[i].e_addr, vecs[i].e_ras, vecs[i].e_cas, vecs[i].e_we,
                   vecs[i].e_ack, vecs[i].e_ready, vecs[i].e_rdata, vecs[i].e_dout, 1'b0});
        end

        // Refresh and request collide in the same IDLE cycle on B
        pulse_reset();
        repeat (16) @(posedge clk);
        #1;
        check1("coll_ready_low", b_ready, 1'b0);
        b_req = 1'b1; b_req_we = 1'b0; b_req_addr = 21'h1AB3C5; b_din = 16'h5A5A;
        @(posedge clk); #1;
        check1("coll_ref_cas", b_cas, 1'b0);
        check1("coll_ref_ras", b_ras, 1'b1);
        check("coll_ref_addr", {43'd0, b_addr}, 64'h0);
        cyc = 17;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (b_ack) got = 1'b1;
        end
        check("coll_ack_cycle", 64'(cyc), 64'd28);
        check("coll_rdata", {48'd0, b_rdata}, {48'd0, 16'h5A5A});
        b_req = 1'b0;
        @(posedge clk); #1;
        check1("coll_ack_single", b_ack, 1'b0);

        // Refresh rotation on idle B; back-to-back requests on C
        pulse_reset();
        c_req = 1'b1;
        check1("c_miss_after_reset", c_miss, 1'b0);
        n_ev = 0; last_fall = 0; prev_cas = b_cas; ras_chk = 1'b0;
        seen_miss = 1'b0; sticky_bad = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            if (ras_chk) begin
                check1($sformatf("ref%0d_ras_fall", n_ev - 1), b_ras, 1'b0);
                ras_chk = 1'b0;
            end
            if (prev_cas && !b_cas) begin
                exp_bank = n_ev[2:0];
                check($sformatf("ref%0d_addr", n_ev), {43'd0, b_addr}, {43'd0, exp_bank, 18'd0});
                check1($sformatf("ref%0d_ras_high", n_ev), b_ras, 1'b1);
                if (n_ev == 0) begin
                    check("ref0_first_cycle", 64'(i), 64'd17);
                end else begin
                    check($sformatf("ref%0d_interval", n_ev), 64'(i - last_fall), 64'd16);
                end
                last_fall = i;
                n_ev++;
                ras_chk = 1'b1;
            end
            prev_cas = b_cas;
            if (c_miss) begin
                seen_miss = 1'b1;
            end else if (seen_miss) begin
                sticky_bad = 1'b1;
            end
            if (i == 100) check1("c_miss_set", c_miss, 1'b1);
        end
        check("ref_event_count", 64'(n_ev), 64'd9);
        check1("b_ref_miss_clear", b_miss, 1'b0);
        check1("c_miss_still_set", c_miss, 1'b1);
        check1("c_miss_sticky", sticky_bad, 1'b0);
        c_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
